// File: rtl/pf_npc.sv
// Pre-fetch next-PC generator: chooses the next fetch address and holds one pending redirect while the pc is stalled.
// Optional redirect counter is built only when PF_REDIRECT_CNT_EN is defined; otherwise redirect_cnt is tied to 0.
module pf_npc #(
  parameter logic [31:0] EXC_VECTOR = 32'hbfc0_0380,
  parameter int          CNT_W      = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      PC,
  input  logic             pc_wr,
  input  logic             exc_flush,
  input  logic             eret_flush,
  input  logic [31:0]      epc,
  input  logic             br_taken,
  input  logic [31:0]      br_target,
  output logic [31:0]      NPC,
  output logic             PF_AdEL,
  output logic             redirect,
  output logic             pend_valid,
  output logic [CNT_W-1:0] redirect_cnt
);

  typedef enum logic {IDLE, HOLD} state_t;
  typedef enum logic [1:0] {KIND_BR = 2'd0, KIND_ERET = 2'd1, KIND_EXC = 2'd2} kind_t;

  state_t      state, state_nxt;
  kind_t       pend_kind, pend_kind_nxt, live_kind;
  logic [31:0] pend_addr, pend_addr_nxt, live_addr;
  logic        live_valid, use_live, consume;

  // Only the highest-priority live request survives; the others are dropped.
  always_comb begin
    live_valid = exc_flush | eret_flush | br_taken;
    live_kind  = KIND_BR;
    live_addr  = br_target;
    if (exc_flush) begin
      live_kind = KIND_EXC;
      live_addr = EXC_VECTOR;
    end else if (eret_flush) begin
      live_kind = KIND_ERET;
      live_addr = epc;
    end
  end

  // Handshake: NPC is offered every cycle; the pc register takes it on a clk
  // edge with pc_wr=1. A redirect offered while pc_wr=0 is parked in HOLD.
  always_comb begin
    use_live   = live_valid && ((state == IDLE) || (live_kind > pend_kind));
    pend_valid = (state == HOLD);
    if (use_live)        NPC = live_addr;
    else if (pend_valid) NPC = pend_addr;
    else                 NPC = PC + 32'd4;
    redirect = use_live | pend_valid;
    PF_AdEL  = (NPC[1:0] != 2'b00);
    consume  = redirect & pc_wr;
  end

  always_comb begin
    state_nxt     = state;
    pend_kind_nxt = pend_kind;
    pend_addr_nxt = pend_addr;
    case (state)
      IDLE: begin
        if (live_valid && !pc_wr) begin
          state_nxt     = HOLD;
          pend_kind_nxt = live_kind;
          pend_addr_nxt = live_addr;
        end
      end
      HOLD: begin
        if (pc_wr) begin
          state_nxt     = IDLE;
          pend_kind_nxt = KIND_BR;
          pend_addr_nxt = 32'd0;
        end else if (use_live) begin
          pend_kind_nxt = live_kind;
          pend_addr_nxt = live_addr;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      pend_kind <= KIND_BR;
      pend_addr <= 32'd0;
    end else begin
      state     <= state_nxt;
      pend_kind <= pend_kind_nxt;
      pend_addr <= pend_addr_nxt;
    end
  end

`ifdef PF_REDIRECT_CNT_EN
  // Saturating count of redirects actually taken by the pc register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                               redirect_cnt <= '0;
    else if (consume && (redirect_cnt != '1)) redirect_cnt <= redirect_cnt + 1'b1;
  end
`else
  assign redirect_cnt = '0;
  logic unused_consume;
  assign unused_consume = consume;
`endif

endmodule

// File: tb/tb_pf_npc.sv
// Directed self-checking bench for pf_npc; expected counter value follows PF_REDIRECT_CNT_EN.
module tb_pf_npc;

  logic        clk;
  logic        rst;
  logic [31:0] PC;
  logic        pc_wr;
  logic        exc_flush;
  logic        eret_flush;
  logic [31:0] epc;
  logic        br_taken;
  logic [31:0] br_target;
  logic [31:0] NPC;
  logic        PF_AdEL;
  logic        redirect;
  logic        pend_valid;
  logic [31:0] redirect_cnt;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_cnt = 32'd0;

`ifdef PF_REDIRECT_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  pf_npc dut (
    .clk          (clk),
    .rst          (rst),
    .PC           (PC),
    .pc_wr        (pc_wr),
    .exc_flush    (exc_flush),
    .eret_flush   (eret_flush),
    .epc          (epc),
    .br_taken     (br_taken),
    .br_target    (br_target),
    .NPC          (NPC),
    .PF_AdEL      (PF_AdEL),
    .redirect     (redirect),
    .pend_valid   (pend_valid),
    .redirect_cnt (redirect_cnt)
  );

  // clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // advance one edge, then settle 1 time unit past it
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    pc_wr      = 1'b0;
    exc_flush  = 1'b0;
    eret_flush = 1'b0;
    br_taken   = 1'b0;
    epc        = 32'd0;
    br_target  = 32'd0;
  endtask

  function automatic logic [31:0] cnt_exp();
    return CNT_EN ? exp_cnt : 32'd0;
  endfunction

  task automatic test_reset();
    idle_inputs();
    PC  = 32'hbfc0_0000;
    rst = 1'b0;
    #12;
    checks++;
    if (pend_valid !== 1'b0) begin errors++; $display("FAIL reset_pend got %b want 0", pend_valid); end
    checks++;
    if (redirect_cnt !== 32'd0) begin errors++; $display("FAIL reset_cnt got %h want 0", redirect_cnt); end
    rst = 1'b1;
    step();
    #1;
    checks++;
    if (NPC !== 32'hbfc0_0004) begin errors++; $display("FAIL reset_npc got %h want bfc00004", NPC); end
    checks++;
    if (redirect !== 1'b0 || PF_AdEL !== 1'b0 || pend_valid !== 1'b0) begin
      errors++; $display("FAIL reset_flags got r=%b a=%b p=%b want 0 0 0", redirect, PF_AdEL, pend_valid);
    end
  endtask

  task automatic test_stall_branch();
    br_taken  = 1'b1;
    br_target = 32'hbfc0_0100;
    pc_wr     = 1'b0;
    #1;
    checks++;
    if (NPC !== 32'hbfc0_0100 || redirect !== 1'b1 || pend_valid !== 1'b0) begin
      errors++; $display("FAIL stall_c0 got npc=%h r=%b p=%b want bfc00100 1 0", NPC, redirect, pend_valid);
    end
    step();
    br_taken = 1'b0;
    for (int i = 0; i < 2; i++) begin
      #1;
      checks++;
      if (NPC !== 32'hbfc0_0100 || pend_valid !== 1'b1 || redirect !== 1'b1) begin
        errors++; $display("FAIL stall_hold%0d got npc=%h p=%b r=%b want bfc00100 1 1", i, NPC, pend_valid, redirect);
      end
      step();
    end
    pc_wr = 1'b1;
    #1;
    checks++;
    if (NPC !== 32'hbfc0_0100) begin errors++; $display("FAIL stall_release_npc got %h want bfc00100", NPC); end
    step();
    exp_cnt++;
    pc_wr = 1'b0;
    PC    = 32'hbfc0_0100;
    #1;
    checks++;
    if (pend_valid !== 1'b0 || NPC !== 32'hbfc0_0104 || redirect !== 1'b0) begin
      errors++; $display("FAIL stall_after got p=%b npc=%h r=%b want 0 bfc00104 0", pend_valid, NPC, redirect);
    end
    checks++;
    if (redirect_cnt !== cnt_exp()) begin errors++; $display("FAIL stall_cnt got %h want %h", redirect_cnt, cnt_exp()); end
  endtask

  task automatic test_exc_preempt();
    br_taken  = 1'b1;
    br_target = 32'hbfc0_0100;
    step();
    br_taken  = 1'b0;
    exc_flush = 1'b1;
    #1;
    checks++;
    if (NPC !== 32'hbfc0_0380 || redirect !== 1'b1) begin
      errors++; $display("FAIL exc_preempt_live got npc=%h r=%b want bfc00380 1", NPC, redirect);
    end
    step();
    exc_flush = 1'b0;
    #1;
    checks++;
    if (NPC !== 32'hbfc0_0380 || pend_valid !== 1'b1) begin
      errors++; $display("FAIL exc_preempt_held got npc=%h p=%b want bfc00380 1", NPC, pend_valid);
    end
    // lower-ranked branch must not displace the pending exception
    br_taken  = 1'b1;
    br_target = 32'h8000_0000;
    #1;
    checks++;
    if (NPC !== 32'hbfc0_0380) begin errors++; $display("FAIL exc_ignores_br_live got %h want bfc00380", NPC); end
    step();
    br_taken = 1'b0;
    #1;
    checks++;
    if (NPC !== 32'hbfc0_0380 || pend_valid !== 1'b1) begin
      errors++; $display("FAIL exc_ignores_br_held got npc=%h p=%b want bfc00380 1", NPC, pend_valid);
    end
    pc_wr = 1'b1;
    step();
    exp_cnt++;
    pc_wr = 1'b0;
    PC    = 32'hbfc0_0380;
    #1;
    checks++;
    if (pend_valid !== 1'b0 || NPC !== 32'hbfc0_0384) begin
      errors++; $display("FAIL exc_release got p=%b npc=%h want 0 bfc00384", pend_valid, NPC);
    end
    checks++;
    if (redirect_cnt !== cnt_exp()) begin errors++; $display("FAIL exc_cnt got %h want %h", redirect_cnt, cnt_exp()); end
  endtask

  task automatic test_eret_over_br_equal_ignored();
    br_taken  = 1'b1;
    br_target = 32'hbfc0_0200;
    step();
    br_taken   = 1'b0;
    eret_flush = 1'b1;
    epc        = 32'h8000_2000;
    step();
    // second eret has equal rank and is ignored
    epc = 32'h8000_3000;
    #1;
    checks++;
    if (NPC !== 32'h8000_2000 || pend_valid !== 1'b1) begin
      errors++; $display("FAIL eret_equal got npc=%h p=%b want 80002000 1", NPC, pend_valid);
    end
    step();
    eret_flush = 1'b0;
    pc_wr      = 1'b1;
    step();
    exp_cnt++;
    pc_wr = 1'b0;
    PC    = 32'h8000_2000;
    #1;
    checks++;
    if (NPC !== 32'h8000_2004 || pend_valid !== 1'b0) begin
      errors++; $display("FAIL eret_release got npc=%h p=%b want 80002004 0", NPC, pend_valid);
    end
  endtask

  task automatic test_priority();
    exc_flush  = 1'b1;
    eret_flush = 1'b1;
    epc        = 32'h8000_1000;
    br_taken   = 1'b1;
    br_target  = 32'h8000_4000;
    pc_wr      = 1'b1;
    #1;
    checks++;
    if (NPC !== 32'hbfc0_0380 || redirect !== 1'b1 || PF_AdEL !== 1'b0) begin
      errors++; $display("FAIL prio_npc got npc=%h r=%b a=%b want bfc00380 1 0", NPC, redirect, PF_AdEL);
    end
    step();
    exp_cnt++;
    idle_inputs();
    PC = 32'hbfc0_0380;
    #1;
    checks++;
    if (pend_valid !== 1'b0 || NPC !== 32'hbfc0_0384) begin
      errors++; $display("FAIL prio_after got p=%b npc=%h want 0 bfc00384", pend_valid, NPC);
    end
    checks++;
    if (redirect_cnt !== cnt_exp()) begin errors++; $display("FAIL prio_cnt got %h want %h", redirect_cnt, cnt_exp()); end
  endtask

  task automatic test_eret_misaligned();
    eret_flush = 1'b1;
    epc        = 32'h8000_1002;
    pc_wr      = 1'b1;
    #1;
    checks++;
    if (NPC !== 32'h8000_1002 || PF_AdEL !== 1'b1) begin
      errors++; $display("FAIL eret_adel got npc=%h a=%b want 80001002 1", NPC, PF_AdEL);
    end
    step();
    exp_cnt++;
    idle_inputs();
    PC = 32'hbfc0_0000;
    #1;
    checks++;
    if (PF_AdEL !== 1'b0 || pend_valid !== 1'b0) begin
      errors++; $display("FAIL eret_adel_after got a=%b p=%b want 0 0", PF_AdEL, pend_valid);
    end
  endtask

  task automatic test_back_to_back();
    br_taken  = 1'b1;
    br_target = 32'hbfc0_0200;
    pc_wr     = 1'b1;
    step();
    exp_cnt++;
    PC        = 32'hbfc0_0200;
    br_target = 32'hbfc0_0300;
    #1;
    checks++;
    if (NPC !== 32'hbfc0_0300 || pend_valid !== 1'b0) begin
      errors++; $display("FAIL b2b_npc got npc=%h p=%b want bfc00300 0", NPC, pend_valid);
    end
    step();
    exp_cnt++;
    idle_inputs();
    PC = 32'hbfc0_0300;
    #1;
    checks++;
    if (NPC !== 32'hbfc0_0304 || redirect_cnt !== cnt_exp()) begin
      errors++; $display("FAIL b2b_after got npc=%h cnt=%h want bfc00304 %h", NPC, redirect_cnt, cnt_exp());
    end
  endtask

  task automatic test_wrap();
    PC = 32'hffff_fffc;
    #1;
    checks++;
    if (NPC !== 32'h0000_0000 || redirect !== 1'b0 || PF_AdEL !== 1'b0) begin
      errors++; $display("FAIL wrap got npc=%h r=%b a=%b want 00000000 0 0", NPC, redirect, PF_AdEL);
    end
    PC = 32'hbfc0_0000;
  endtask

  task automatic test_async_reset();
    br_taken  = 1'b1;
    br_target = 32'hbfc0_0500;
    step();
    br_taken = 1'b0;
    #1;
    checks++;
    if (pend_valid !== 1'b1) begin errors++; $display("FAIL areset_pre got p=%b want 1", pend_valid); end
    #1;
    rst = 1'b0;
    #1;
    exp_cnt = 32'd0;
    checks++;
    if (pend_valid !== 1'b0 || redirect_cnt !== 32'd0 || NPC !== 32'hbfc0_0004) begin
      errors++; $display("FAIL areset got p=%b cnt=%h npc=%h want 0 0 bfc00004", pend_valid, redirect_cnt, NPC);
    end
    step();
    rst = 1'b1;
    step();
    checks++;
    if (pend_valid !== 1'b0 || redirect !== 1'b0) begin
      errors++; $display("FAIL areset_after got p=%b r=%b want 0 0", pend_valid, redirect);
    end
  endtask

  initial begin
    test_reset();
    test_stall_branch();
    test_exc_preempt();
    test_eret_over_br_equal_ignored();
    test_priority();
    test_eret_misaligned();
    test_back_to_back();
    test_wrap();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pf_npc.md
Name: pf_npc

Overview:
- Pre-fetch next-PC generator, directly upstream of the pc register; drives its NPC and PF_AdEL inputs.
- Selects the next fetch address from four sources: exception vector, eret EPC, branch/jump target, and sequential PC+4.
- Holds a single pending redirect, so a redirect raised while pc is stalled (pc_wr=0) is not lost.
- Reports fetch-address alignment errors and counts taken redirects.

Parameters:
- EXC_VECTOR, 32'hbfc0_0380, general exception entry address.
- CNT_W, 32, width of redirect_cnt.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous reset, active-low.
- PC  in  32  current pc register value.
- pc_wr  in  1  pc register write enable; NPC is consumed on the clk edge when this is 1.
- exc_flush  in  1  exception commit, single-cycle pulse.
- eret_flush  in  1  eret commit, single-cycle pulse.
- epc  in  32  CP0 EPC, valid with eret_flush.
- br_taken  in  1  ID-stage branch/jump taken, single-cycle pulse.
- br_target  in  32  branch/jump target, valid with br_taken.
- NPC  out  32  next fetch address.
- PF_AdEL  out  1  NPC misaligned.
- redirect  out  1  NPC is not PC+4 this cycle.
- pend_valid  out  1  pending redirect held.
- redirect_cnt  out  CNT_W  count of redirects consumed.

Behaviour:
- Reset is asynchronous on negedge rst. pend_valid, pend_kind and pend_addr go to 0, and redirect_cnt goes to 0.
- With PC=32'hbfc0_0000 and no requests after reset: NPC=32'hbfc0_0004, PF_AdEL=0, redirect=0.
- Live request priority in the same cycle: exc_flush > eret_flush > br_taken. Lower-priority simultaneous requests are dropped.
- Live-request addresses:
  - exc_flush -> EXC_VECTOR.
  - eret_flush -> epc.
  - br_taken -> br_target.
- Pending state is pend_kind (2 bits: EXC=2, ERET=1, BR=0) plus pend_addr (32 bits).
- NPC selection (combinational, zero latency):
  - If a live request exists and it outranks the pending one (or nothing is pending), NPC = live address.
  - Otherwise, if pend_valid, NPC = pend_addr.
  - Otherwise NPC = PC+4, modulo 2^32; 32'hffff_fffc wraps to 32'h0000_0000.
- redirect = 1 whenever NPC comes from a live or pending source.
- State machine, two states:
  - IDLE (pend_valid=0):
    - Live request with pc_wr=0 -> HOLD; capture the winning kind and address.
    - Live request with pc_wr=1 -> stay in IDLE; the request is consumed immediately.
  - HOLD (pend_valid=1):
    - pc_wr=1 -> IDLE on that edge, whether NPC is pend_addr or an outranking live address.
    - pc_wr=0 with a live request of strictly higher kind -> overwrite pend_kind and pend_addr.
    - pc_wr=0 with an equal or lower live request -> ignore it; the pending entry is kept.
- A redirect is consumed on a clk edge when redirect=1 and pc_wr=1.
- redirect_cnt increments by 1 per consumed redirect and saturates at all-ones.
- PF_AdEL = (NPC[1:0] != 2'b00), combinational from the final NPC. This applies to all sources, including a misaligned epc or br_target.
- EXC_VECTOR and PC+4 are always aligned when PC is aligned.
- Back-to-back case: request consumed in cycle N with pc_wr=1, new br_taken in cycle N+1 -> handled as fresh; nothing is left over from cycle N.
- A reset asserted while in HOLD discards the pending redirect immediately; no clk edge is required.

Optional Feature:
- Macro: PF_REDIRECT_CNT_EN.
- Defined: redirect_cnt is implemented as described above.
- Undefined: no counter flops are built and redirect_cnt is tied to 0. All other behaviour is identical.

Test Plan:
- Reset then release with PC=32'hbfc0_0000, no requests -> NPC=32'hbfc0_0004, redirect=0, pend_valid=0, PF_AdEL=0.
- br_taken=1, br_target=32'hbfc0_0100, pc_wr=0 for 3 cycles, then pc_wr=1:
  - NPC=32'hbfc0_0100 throughout; pend_valid=1 from the next cycle.
  - After the pc_wr edge: pend_valid=0, NPC=PC+4, redirect_cnt=1.
- Pending BR (32'hbfc0_0100) stalled, then exc_flush pulse -> NPC=32'hbfc0_0380, pend_kind=EXC. On pc_wr=1, pc loads 32'hbfc0_0380; the branch is never taken.
- Pending EXC stalled, then br_taken to 32'h8000_0000 -> NPC stays 32'hbfc0_0380; the branch is ignored.
- Same-cycle exc_flush, eret_flush (epc=32'h8000_1000) and br_taken, with pc_wr=1 -> NPC=32'hbfc0_0380, redirect_cnt +1 only, pend_valid stays 0.
- eret_flush with epc=32'h8000_1002, pc_wr=1 -> NPC=32'h8000_1002, PF_AdEL=1.
- In HOLD, drop rst mid-cycle -> pend_valid=0 and redirect_cnt=0 asynchronously.
- PC=32'hffff_fffc with no requests -> NPC=32'h0000_0000.
